mem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port data memory (64 x 32-bit, byte address, word index addr/4).
- Accepts a request from either port and drives the memory control and address/data lines for a fixed number of wait cycles.
- Returns read data with a one-cycle ack pulse, then releases the memory.
- Port 0 is typically the load/store unit and port 1 a debug/DMA master.

---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Optional macro ARB_ROUND_ROBIN_EN turns tie-breaking from fixed port-0 priority into round robin.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clock_in,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  CNT_LOAD   = 4'(WAIT_CYCLES - 1);

    function automatic logic addr_legal(input logic [31:0] a);
        addr_legal = (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        winner_q, winner_d;
    logic        err_flag_q, err_flag_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        ack0_q, ack0_d, ack1_q, ack1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        busy_q, busy_d;

    logic        grant_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic        legal_s;
    logic [31:0] rd_s;

    // Winner selection for a request seen in IDLE
    always_comb begin
        grant_s = 1'b0;
        if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_s = ~last_grant_q;
`else
            grant_s = 1'b0;
`endif
        end else begin
            grant_s = ~req0;
        end
        sel_we_s   = grant_s ? we1 : we0;
        sel_addr_s = grant_s ? addr1 : addr0;
        legal_s    = addr_legal(sel_addr_s);
        rd_s       = mem_read_q ? mem_rdata : 32'h0000_0000;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        err_flag_d   = err_flag_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        ack0_d       = ack0_q;
        ack1_d       = ack1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        busy_d       = busy_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner_d    = grant_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = grant_s ? wdata1 : wdata0;
                    cnt_d       = CNT_LOAD;
                    mem_read_d  = legal_s & ~sel_we_s;
                    mem_write_d = legal_s & sel_we_s;
                    err_flag_d  = ~legal_s;
                    busy_d      = 1'b1;
                    state_d     = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (winner_q) begin
                        rdata1_d = rd_s;
                        ack1_d   = 1'b1;
                        err1_d   = err_flag_q;
                    end else begin
                        rdata0_d = rd_s;
                        ack0_d   = 1'b1;
                        err0_d   = err_flag_q;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                ack0_d       = 1'b0;
                ack1_d       = 1'b0;
                err0_d       = 1'b0;
                err1_d       = 1'b0;
                last_grant_d = winner_q;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                ack0_d      = 1'b0;
                ack1_d      = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State registers; reset drops any transaction in flight
    always_ff @(posedge clock_in or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            err_flag_q   <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            mem_wdata_q  <= 32'h0000_0000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'h0000_0000;
            rdata1_q     <= 32'h0000_0000;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            err_flag_q   <= err_flag_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule
